run_ctrl: RTL and testbench
===========================

# run_ctrl

Run controller for the pipelined RSA CPU system. It sits between the system's top-level ports, the `arm` core and the data memory. It holds the core in reset until a `start` request arrives, then lets it run until the PC reaches a halt address or a cycle budget expires. Outside a run, it gives an external host exclusive access to data memory so keys and messages can be loaded and results read back. It replaces the bare start-to-core wiring with parametrised halt detection, pipeline drain, timeout, cycle counting and a host memory port.

## Interface
Parameters:
- `DATA_W`, 32, data word width
- `ADDR_W`, 32, byte address width (CPU and host)
- `HALT_PC`, 32'h0000_00FC, PC value that marks program end
- `DRAIN_CYC`, 4, cycles the core keeps running after halt detection so in-flight stores retire (≥1)
- `MAX_CYCLES`, 100000, RUN-cycle budget before timeout (≥2)

Ports:
- `clk` in 1: system clock
- `reset` in 1: synchronous, active-high
- `start` in 1: run request, level-sampled
- `cpu_reset` out 1: reset to `arm`
- `cpu_pc` in ADDR_W: core PC
- `cpu_memwrite` in 1: core store enable
- `cpu_adr` in ADDR_W: core data address
- `cpu_wdata` in DATA_W: core store data
- `cpu_rdata` out DATA_W: load data to core
- `flag_zero_in` in 1: core zero flag
- `ext_we` in 1: host write enable
- `ext_addr` in ADDR_W: host address
- `ext_wdata` in DATA_W: host write data
- `ext_rdata` out DATA_W: host read data
- `mem_we` out 1: to dmem write enable
- `mem_adr` out ADDR_W: to dmem address
- `mem_wdata` out DATA_W: to dmem write data
- `mem_rdata` in DATA_W: from dmem, combinational read
- `busy` out 1: CLEAR, RUN or DRAIN
- `done` out 1: in DONE
- `timeout` out 1: last run ended by budget
- `flag_zero` out 1: `flag_zero_in` captured at halt
- `cycle_count` out 32: RUN cycles of last/current run

## Operation
- States:
  - IDLE: power-up state.
  - CLEAR: exactly 1 cycle.
  - RUN: core executes.
  - DRAIN: core finishes in-flight work.
  - DONE: run ended.
- Transitions:
  - IDLE/DONE → CLEAR when `start`=1. In DONE, `start` also clears `done`, `timeout` and `flag_zero` on entry to CLEAR.
  - CLEAR → RUN, unconditional. `cycle_count` is cleared to 0 in CLEAR.
  - RUN: if `cpu_pc`==HALT_PC → DRAIN. Else, if `cycle_count`==MAX_CYCLES−1 → DONE and set `timeout`. Halt wins when both conditions hold in the same cycle.
  - DRAIN → DONE after DRAIN_CYC cycles in DRAIN. An internal down-counter is loaded on RUN exit.
- `start` is ignored in CLEAR, RUN and DRAIN.
- `cycle_count` increments every RUN cycle, including the exit cycle. It holds in all other states, so a timed-out run shows MAX_CYCLES.
- `flag_zero` captures `flag_zero_in` on the DRAIN→DONE transition. On timeout, it captures on the RUN→DONE transition.
- `cpu_reset` = 1 in IDLE, CLEAR and DONE; 0 in RUN and DRAIN.
- Memory mux:
  - In RUN/DRAIN: `mem_*` = `cpu_*`, `cpu_rdata` = `mem_rdata`. `ext_we` is dropped with no effect, and `ext_rdata` = 0.
  - Otherwise: `mem_we` = `ext_we`, `mem_adr` = `ext_addr`, `mem_wdata` = `ext_wdata`, `ext_rdata` = `mem_rdata`. `cpu_rdata` = 0.
- The mux is purely combinational on the registered state.

## Timing
- Reset (sync, next edge) puts the block in IDLE with:
  - `cpu_reset`=1
  - `busy`=0, `done`=0, `timeout`=0, `flag_zero`=0
  - `cycle_count`=0
- Reset mid-run aborts immediately. Memory contents written so far persist.
- `start` high at edge N in IDLE gives CLEAR during cycle N+1 and RUN from N+2. `cpu_reset` falls at start of cycle N+2.
- Halt seen at edge M gives DRAIN for cycles M+1 … M+DRAIN_CYC. DONE and `done`=1 begin at M+DRAIN_CYC+1.
- `busy` and `done` are decoded from the state register, so they are glitch-free.
- `start` held high through DONE starts a new run on the first DONE edge. `done` is high for exactly 1 cycle in that case.
- `cycle_count` is 32-bit unsigned and never wraps, because MAX_CYCLES < 2^32.
- Host writes take effect on the clock edge, with dmem semantics. Host reads are combinational in the same cycle.

## Test plan
- Reset then host load: write 0x12345678 to addr 0x10 in IDLE, read back → `ext_rdata`=0x12345678, `busy`=0, `cpu_reset`=1.
- Normal run: `start` pulse at cycle 0, model `cpu_pc`=HALT_PC at RUN cycle 20 with `flag_zero_in`=1 → `cycle_count`=20, `done` at cycle 2+20+DRAIN_CYC, `flag_zero`=1, `timeout`=0.
- Timeout with MAX_CYCLES=50 and PC never reaching halt → DONE after 50 RUN cycles, `timeout`=1, `cycle_count`=50, no DRAIN.
- Halt and budget coincide: `cpu_pc`=HALT_PC on RUN cycle 50 with MAX_CYCLES=50 → DRAIN taken, `timeout`=0.
- Isolation: `ext_we`=1 to addr 0x10 during RUN → dmem unchanged. A CPU store of 0xA5 to 0x20 in DRAIN lands, and reads back 0xA5 from the host in DONE.
- Reset at RUN cycle 7 → next cycle IDLE, `cpu_reset`=1, `cycle_count`=0. A subsequent `start` runs normally.

Source files
------------

// File: rtl/run_ctrl.sv
// Run controller: holds the core in reset until start, runs it to a halt PC or cycle budget,
// and hands data memory to an external host whenever the core is not running.
module run_ctrl #(
  parameter int unsigned         DATA_W     = 32,
  parameter int unsigned         ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]   HALT_PC    = 32'h0000_00FC,
  parameter int unsigned         DRAIN_CYC  = 4,
  parameter int unsigned         MAX_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              cpu_reset,
  input  logic [ADDR_W-1:0] cpu_pc,
  input  logic              cpu_memwrite,
  input  logic [ADDR_W-1:0] cpu_adr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              flag_zero_in,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              flag_zero,
  output logic [31:0]       cycle_count
);

  localparam int unsigned DrainW    = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [31:0] LastCycle = 32'(MAX_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRun,
    StDrain,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         cycle_q, cycle_d;
  logic [DrainW-1:0]   drain_q, drain_d;
  logic                timeout_q, timeout_d;
  logic                flag_zero_q, flag_zero_d;
  logic                core_owns_mem;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cycle_q     <= '0;
      drain_q     <= '0;
      timeout_q   <= 1'b0;
      flag_zero_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cycle_q     <= cycle_d;
      drain_q     <= drain_d;
      timeout_q   <= timeout_d;
      flag_zero_q <= flag_zero_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cycle_d     = cycle_q;
    drain_d     = drain_q;
    timeout_d   = timeout_q;
    flag_zero_d = flag_zero_q;

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StClear;
      end
      StClear: begin
        state_d = StRun;
        cycle_d = '0;
      end
      StRun: begin
        cycle_d = cycle_q + 32'd1;
        // Halt takes priority over an expiring budget in the same cycle.
        if (cpu_pc == HALT_PC) begin
          state_d = StDrain;
          drain_d = DrainW'(DRAIN_CYC - 1);
        end else if (cycle_q == LastCycle) begin
          state_d     = StDone;
          timeout_d   = 1'b1;
          flag_zero_d = flag_zero_in;
        end
      end
      StDrain: begin
        if (drain_q == '0) begin
          state_d     = StDone;
          flag_zero_d = flag_zero_in;
        end else begin
          drain_d = drain_q - DrainW'(1);
        end
      end
      StDone: begin
        if (start) begin
          state_d     = StClear;
          timeout_d   = 1'b0;
          flag_zero_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign core_owns_mem = (state_q == StRun) || (state_q == StDrain);

  always_comb begin
    cpu_reset = ~core_owns_mem;
    busy      = (state_q == StClear) || core_owns_mem;
    done      = (state_q == StDone);
    if (core_owns_mem) begin
      mem_we    = cpu_memwrite;
      mem_adr   = cpu_adr;
      mem_wdata = cpu_wdata;
      cpu_rdata = mem_rdata;
      ext_rdata = '0;
    end else begin
      mem_we    = ext_we;
      mem_adr   = ext_addr;
      mem_wdata = ext_wdata;
      cpu_rdata = '0;
      ext_rdata = mem_rdata;
    end
  end

  assign timeout     = timeout_q;
  assign flag_zero   = flag_zero_q;
  assign cycle_count = cycle_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: a small dmem plus a run model that predicts phase lengths,
// counts and captured flags from the halt cycle of each randomized run.
module tb_run_ctrl;

  localparam int          MaxC   = 50;
  localparam int          DrainC = 4;
  localparam logic [31:0] Halt   = 32'h0000_00FC;

  logic        clk = 1'b0;
  logic        reset, start;
  logic        cpu_reset;
  logic [31:0] cpu_pc, cpu_adr, cpu_wdata, cpu_rdata;
  logic        cpu_memwrite, flag_zero_in;
  logic        ext_we;
  logic [31:0] ext_addr, ext_wdata, ext_rdata;
  logic        mem_we;
  logic [31:0] mem_adr, mem_wdata, mem_rdata;
  logic        busy, done, timeout, flag_zero;
  logic [31:0] cycle_count;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [0:63];

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) mem[mem_adr[7:2]] <= mem_wdata;
  assign mem_rdata = mem[mem_adr[7:2]];

  run_ctrl #(
    .DATA_W    (32),
    .ADDR_W    (32),
    .HALT_PC   (Halt),
    .DRAIN_CYC (DrainC),
    .MAX_CYCLES(MaxC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .cpu_reset   (cpu_reset),
    .cpu_pc      (cpu_pc),
    .cpu_memwrite(cpu_memwrite),
    .cpu_adr     (cpu_adr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .flag_zero_in(flag_zero_in),
    .ext_we      (ext_we),
    .ext_addr    (ext_addr),
    .ext_wdata   (ext_wdata),
    .ext_rdata   (ext_rdata),
    .mem_we      (mem_we),
    .mem_adr     (mem_adr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .flag_zero   (flag_zero),
    .cycle_count (cycle_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    p = $urandom & 32'hFFFF_FFFC;
    if (p == Halt) p = p + 32'd4;
    return p;
  endfunction

  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Entered while in CLEAR; h is the 1-based RUN cycle showing the halt PC (h > MaxC: never).
  // Ends in DONE. hold keeps start high from the first RUN cycle onward.
  task automatic run_body(input int h, input bit hold, input bit iso, input string tag);
    int   run_len;
    bit   exp_to;
    logic exp_fz;
    exp_to  = (h > MaxC);
    run_len = exp_to ? MaxC : h;
    exp_fz  = 1'b0;

    checks++;
    if ({cpu_reset, busy, done} !== 3'b110) begin
      failures++;
      $display("FAIL %s clear_ctl got=%b want=110", tag, {cpu_reset, busy, done});
    end
    step();
    if (hold) start = 1'b1;

    for (int i = 1; i <= run_len; i++) begin
      cpu_pc       = (i == h) ? Halt : rand_pc();
      flag_zero_in = 1'($urandom_range(0, 1));
      if (exp_to) exp_fz = flag_zero_in;
      if (iso && i == 3) begin
        ext_we       = 1'b1;
        ext_addr     = 32'h10;
        ext_wdata    = 32'hDEAD_BEEF;
        cpu_adr      = 32'h10;
        cpu_memwrite = 1'b0;
      end
      #1;
      checks++;
      if ({cpu_reset, busy, done} !== 3'b010 || cycle_count !== 32'(i - 1)) begin
        failures++;
        $display("FAIL %s run_cyc%0d ctl=%b cnt=%0d want ctl=010 cnt=%0d",
                 tag, i, {cpu_reset, busy, done}, cycle_count, i - 1);
      end
      if (iso && i == 3) begin
        checks++;
        if (mem_we !== 1'b0 || ext_rdata !== 32'h0 || cpu_rdata !== 32'h1234_5678) begin
          failures++;
          $display("FAIL %s run_iso we=%b ext_rdata=%h cpu_rdata=%h want 0/0/12345678",
                   tag, mem_we, ext_rdata, cpu_rdata);
        end
      end
      step();
      ext_we = 1'b0;
    end
    cpu_pc = rand_pc();

    if (!exp_to) begin
      for (int d = 0; d < DrainC; d++) begin
        flag_zero_in = 1'($urandom_range(0, 1));
        exp_fz       = flag_zero_in;
        if (iso && d == 1) begin
          cpu_memwrite = 1'b1;
          cpu_adr      = 32'h20;
          cpu_wdata    = 32'hA5;
        end
        #1;
        checks++;
        if ({cpu_reset, busy, done} !== 3'b010 || cycle_count !== 32'(run_len)) begin
          failures++;
          $display("FAIL %s drain%0d ctl=%b cnt=%0d want ctl=010 cnt=%0d",
                   tag, d, {cpu_reset, busy, done}, cycle_count, run_len);
        end
        if (iso && d == 1) begin
          checks++;
          if ({mem_we, mem_adr, mem_wdata} !== {1'b1, 32'h20, 32'hA5}) begin
            failures++;
            $display("FAIL %s drain_store we=%b adr=%h wdata=%h want 1/20/a5",
                     tag, mem_we, mem_adr, mem_wdata);
          end
        end
        step();
        cpu_memwrite = 1'b0;
      end
    end

    flag_zero_in = ~exp_fz;
    #1;
    checks++;
    if ({cpu_reset, busy, done} !== 3'b101 || timeout !== exp_to ||
        cycle_count !== 32'(run_len) || flag_zero !== exp_fz) begin
      failures++;
      $display("FAIL %s done ctl=%b to=%b cnt=%0d fz=%b want ctl=101 to=%b cnt=%0d fz=%b",
               tag, {cpu_reset, busy, done}, timeout, cycle_count, flag_zero,
               exp_to, run_len, exp_fz);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    checks++;
    if ({cpu_reset, busy, done, timeout, flag_zero} !== 5'b10000 || cycle_count !== 32'd0) begin
      failures++;
      $display("FAIL reset ctl=%b cnt=%0d want 10000 cnt=0",
               {cpu_reset, busy, done, timeout, flag_zero}, cycle_count);
    end
  endtask

  task automatic test_host_load();
    ext_we    = 1'b1;
    ext_addr  = 32'h10;
    ext_wdata = 32'h1234_5678;
    #1;
    checks++;
    if (mem_we !== 1'b1 || mem_adr !== 32'h10 || mem_wdata !== 32'h1234_5678) begin
      failures++;
      $display("FAIL host_mux we=%b adr=%h wdata=%h want 1/10/12345678",
               mem_we, mem_adr, mem_wdata);
    end
    step();
    ext_we = 1'b0;
    #1;
    checks++;
    if (ext_rdata !== 32'h1234_5678 || busy !== 1'b0 || cpu_reset !== 1'b1 ||
        cpu_rdata !== 32'h0) begin
      failures++;
      $display("FAIL host_read rdata=%h busy=%b cpu_reset=%b cpu_rdata=%h want 12345678/0/1/0",
               ext_rdata, busy, cpu_reset, cpu_rdata);
    end
  endtask

  task automatic test_normal();
    kick();
    run_body(20, 1'b0, 1'b0, "normal");
  endtask

  task automatic test_timeout();
    kick();
    run_body(MaxC + 1, 1'b0, 1'b0, "timeout");
  endtask

  task automatic test_coincide();
    kick();
    run_body(MaxC, 1'b0, 1'b0, "coincide");
  endtask

  task automatic test_isolation();
    kick();
    run_body(12, 1'b0, 1'b1, "iso");
    ext_addr = 32'h20;
    #1;
    checks++;
    if (ext_rdata !== 32'hA5) begin
      failures++;
      $display("FAIL iso_readback_20 got=%h want=000000a5", ext_rdata);
    end
    ext_addr = 32'h10;
    #1;
    checks++;
    if (ext_rdata !== 32'h1234_5678) begin
      failures++;
      $display("FAIL iso_readback_10 got=%h want=12345678", ext_rdata);
    end
  endtask

  task automatic test_back_to_back();
    kick();
    run_body(MaxC + 1, 1'b1, 1'b0, "b2b_first");
    step();
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || timeout !== 1'b0 || flag_zero !== 1'b0) begin
      failures++;
      $display("FAIL b2b_clear done=%b to=%b fz=%b want 0/0/0", done, timeout, flag_zero);
    end
    run_body(7, 1'b0, 1'b0, "b2b_second");
  endtask

  task automatic test_reset_mid_run();
    kick();
    step();
    for (int i = 1; i < 7; i++) begin
      cpu_pc = rand_pc();
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({cpu_reset, busy, done, timeout} !== 4'b1000 || cycle_count !== 32'd0) begin
      failures++;
      $display("FAIL mid_reset ctl=%b cnt=%0d want 1000 cnt=0",
               {cpu_reset, busy, done, timeout}, cycle_count);
    end
    kick();
    run_body(15, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      step();
      kick();
      run_body(int'($urandom_range(1, MaxC + 10)), 1'b0, 1'b0, "random");
    end
  endtask

  initial begin
    reset        = 1'b0;
    start        = 1'b0;
    cpu_pc       = 32'h0;
    cpu_memwrite = 1'b0;
    cpu_adr      = 32'h0;
    cpu_wdata    = 32'h0;
    flag_zero_in = 1'b0;
    ext_we       = 1'b0;
    ext_addr     = 32'h0;
    ext_wdata    = 32'h0;
    step();
    test_reset();
    test_host_load();
    test_normal();
    test_timeout();
    test_coincide();
    test_isolation();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
